// File: rtl/execute_ldst_align_unit.sv
// Execute-stage load/store aligner: issues bus-aligned beats with lane masks and merges returned load data.
// Define EXE_LDST_MISALIGN_SPLIT_EN to split bus-crossing accesses into two beats; otherwise they fault.
module execute_ldst_align_unit #(
  parameter int P_DATA_W = 32,
  parameter int P_ADDR_W = 32,
  localparam int P_LANE_W = P_DATA_W / 8
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iPREV_VALID,
  output logic                oPREV_BUSY,
  input  logic                iPREV_RW,
  input  logic [1:0]          iPREV_ORDER,
  input  logic [P_ADDR_W-1:0] iPREV_ADDR,
  input  logic [P_DATA_W-1:0] iPREV_DATA,
  output logic                oLDST_REQ,
  input  logic                iLDST_BUSY,
  output logic                oLDST_RW,
  output logic [P_ADDR_W-1:0] oLDST_ADDR,
  output logic [P_DATA_W-1:0] oLDST_DATA,
  output logic [P_LANE_W-1:0] oLDST_MASK,
  input  logic                iLDST_VALID,
  input  logic [P_DATA_W-1:0] iLDST_DATA,
  output logic                oNEXT_VALID,
  input  logic                iNEXT_BUSY,
  output logic [P_DATA_W-1:0] oNEXT_DATA,
  output logic                oNEXT_FAULT
);
  localparam int OFF_W = $clog2(P_LANE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                prevBusy_q;
  logic                ldstReq_q;
  logic                ldstRw_q;
  logic [P_ADDR_W-1:0] ldstAddr_q;
  logic [P_DATA_W-1:0] ldstData_q;
  logic [P_LANE_W-1:0] ldstMask_q;
  logic                nextValid_q;
  logic [P_DATA_W-1:0] nextData_q;
  logic                nextFault_q;
  logic                rw_q;
  logic [1:0]          order_q;
  logic [OFF_W-1:0]    off_q;
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
  logic                split_q;
  logic [P_ADDR_W-1:0] secAddr_q;
  logic [P_LANE_W-1:0] secMask_q;
  logic [P_DATA_W-1:0] secData_q;
  logic [P_DATA_W-1:0] beat0_q;
  logic [P_DATA_W-1:0] data1_d;
`endif

  logic [OFF_W-1:0]    off_d;
  logic [P_LANE_W-1:0] mask0_d;
  logic [P_LANE_W-1:0] mask1_d;
  logic [P_DATA_W-1:0] data0_d;
  logic [P_ADDR_W-1:0] addrAlign_d;
  logic                legal_d;
  logic                split_d;

  // Byte-lane enables for an access size, wide enough to spill into the next bus word.
  function automatic logic [2*P_LANE_W-1:0] sizeLanes(input logic [1:0] ord);
    logic [2*P_LANE_W-1:0] m;
    for (int i = 0; i < 2*P_LANE_W; i++) m[i] = (i < (1 << ord));
    return m;
  endfunction

  function automatic logic [P_DATA_W-1:0] mergeLoad(input logic [2*P_DATA_W-1:0] beats,
                                                    input logic [OFF_W-1:0]      off,
                                                    input logic [1:0]            ord);
    logic [2*P_DATA_W-1:0] sh;
    logic [P_DATA_W-1:0]   bm;
    sh = beats >> {off, 3'b000};
    for (int i = 0; i < P_DATA_W; i++) bm[i] = (i < (8 << ord));
    return sh[P_DATA_W-1:0] & bm;
  endfunction

  always_comb begin
    off_d               = iPREV_ADDR[OFF_W-1:0];
    addrAlign_d         = {iPREV_ADDR[P_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    legal_d             = (P_DATA_W == 64) || (iPREV_ORDER != 2'd3);
    {mask1_d, mask0_d}  = sizeLanes(iPREV_ORDER) << off_d;
    split_d             = |mask1_d;
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
    {data1_d, data0_d}  = {{P_DATA_W{1'b0}}, iPREV_DATA} << {off_d, 3'b000};
`else
    data0_d             = iPREV_DATA << {off_d, 3'b000};
`endif
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q     <= S_IDLE;
      prevBusy_q  <= 1'b0;
      ldstReq_q   <= 1'b0;
      ldstRw_q    <= 1'b0;
      ldstAddr_q  <= '0;
      ldstData_q  <= '0;
      ldstMask_q  <= '0;
      nextValid_q <= 1'b0;
      nextData_q  <= '0;
      nextFault_q <= 1'b0;
      rw_q        <= 1'b0;
      order_q     <= 2'd0;
      off_q       <= '0;
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      secAddr_q   <= '0;
      secMask_q   <= '0;
      secData_q   <= '0;
      beat0_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iPREV_VALID) begin
            prevBusy_q <= 1'b1;
            rw_q       <= iPREV_RW;
            order_q    <= iPREV_ORDER;
            off_q      <= off_d;
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
            split_q    <= split_d;
            secAddr_q  <= addrAlign_d + P_ADDR_W'(P_LANE_W);
            secMask_q  <= mask1_d;
            secData_q  <= data1_d;
`endif
            // Faulting requests never touch the bus and report straight away.
            if (!legal_d
`ifndef EXE_LDST_MISALIGN_SPLIT_EN
                || split_d
`endif
               ) begin
              state_q     <= S_DONE;
              nextValid_q <= 1'b1;
              nextFault_q <= 1'b1;
              nextData_q  <= '0;
            end else begin
              state_q     <= S_REQ0;
              nextFault_q <= 1'b0;
              ldstReq_q   <= 1'b1;
              ldstRw_q    <= iPREV_RW;
              ldstAddr_q  <= addrAlign_d;
              ldstMask_q  <= mask0_d;
              ldstData_q  <= data0_d;
            end
          end
        end
        S_REQ0: begin
          if (!iLDST_BUSY) begin
            ldstReq_q <= 1'b0;
            state_q   <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (iLDST_VALID) begin
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
            if (split_q) begin
              beat0_q    <= iLDST_DATA;
              state_q    <= S_REQ1;
              ldstReq_q  <= 1'b1;
              ldstAddr_q <= secAddr_q;
              ldstMask_q <= secMask_q;
              ldstData_q <= secData_q;
            end else
`endif
            begin
              state_q     <= S_DONE;
              nextValid_q <= 1'b1;
              nextData_q  <= rw_q ? '0 : mergeLoad({{P_DATA_W{1'b0}}, iLDST_DATA}, off_q, order_q);
            end
          end
        end
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
        S_REQ1: begin
          if (!iLDST_BUSY) begin
            ldstReq_q <= 1'b0;
            state_q   <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (iLDST_VALID) begin
            state_q     <= S_DONE;
            nextValid_q <= 1'b1;
            nextData_q  <= rw_q ? '0 : mergeLoad({iLDST_DATA, beat0_q}, off_q, order_q);
          end
        end
`endif
        S_DONE: begin
          if (!iNEXT_BUSY) begin
            nextValid_q <= 1'b0;
            prevBusy_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oPREV_BUSY  = prevBusy_q;
  assign oLDST_REQ   = ldstReq_q;
  assign oLDST_RW    = ldstRw_q;
  assign oLDST_ADDR  = ldstAddr_q;
  assign oLDST_DATA  = ldstData_q;
  assign oLDST_MASK  = ldstMask_q;
  assign oNEXT_VALID = nextValid_q;
  assign oNEXT_DATA  = nextData_q;
  assign oNEXT_FAULT = nextFault_q;

endmodule

// File: tb/tb_execute_ldst_align_unit.sv
// Directed, table-driven bench for execute_ldst_align_unit (32-bit bus); expectations follow EXE_LDST_MISALIGN_SPLIT_EN.
module tb_execute_ldst_align_unit;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC = 1'b1;
  logic        iPREV_VALID = 1'b0;
  logic        oPREV_BUSY;
  logic        iPREV_RW = 1'b0;
  logic [1:0]  iPREV_ORDER = 2'd0;
  logic [31:0] iPREV_ADDR = 32'h0;
  logic [31:0] iPREV_DATA = 32'h0;
  logic        oLDST_REQ;
  logic        iLDST_BUSY = 1'b0;
  logic        oLDST_RW;
  logic [31:0] oLDST_ADDR;
  logic [31:0] oLDST_DATA;
  logic [3:0]  oLDST_MASK;
  logic        iLDST_VALID = 1'b0;
  logic [31:0] iLDST_DATA = 32'h0;
  logic        oNEXT_VALID;
  logic        iNEXT_BUSY = 1'b0;
  logic [31:0] oNEXT_DATA;
  logic        oNEXT_FAULT;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  order;
    logic [31:0] addr;
    logic [31:0] data;
    int          nTxn;
    logic [31:0] addr0;
    logic [3:0]  mask0;
    logic [31:0] data0;
    logic [31:0] addr1;
    logic [3:0]  mask1;
    logic [31:0] data1;
    logic [31:0] result;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  execute_ldst_align_unit #(.P_DATA_W(32), .P_ADDR_W(32)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
    .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(oPREV_BUSY), .iPREV_RW(iPREV_RW),
    .iPREV_ORDER(iPREV_ORDER), .iPREV_ADDR(iPREV_ADDR), .iPREV_DATA(iPREV_DATA),
    .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY), .oLDST_RW(oLDST_RW),
    .oLDST_ADDR(oLDST_ADDR), .oLDST_DATA(oLDST_DATA), .oLDST_MASK(oLDST_MASK),
    .iLDST_VALID(iLDST_VALID), .iLDST_DATA(iLDST_DATA),
    .oNEXT_VALID(oNEXT_VALID), .iNEXT_BUSY(iNEXT_BUSY),
    .oNEXT_DATA(oNEXT_DATA), .oNEXT_FAULT(oNEXT_FAULT)
  );

  always #5 iCLOCK = ~iCLOCK;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hAABB_CCDD;
      32'h0000_1004: return 32'h1122_3344;
      default:       return 32'h0102_0304;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " prevBusy"}, {31'd0, oPREV_BUSY}, 32'd0);
    checkOutput({tag, " ldstReq"}, {31'd0, oLDST_REQ}, 32'd0);
    checkOutput({tag, " ldstRw"}, {31'd0, oLDST_RW}, 32'd0);
    checkOutput({tag, " ldstAddr"}, oLDST_ADDR, 32'd0);
    checkOutput({tag, " ldstData"}, oLDST_DATA, 32'd0);
    checkOutput({tag, " ldstMask"}, {28'd0, oLDST_MASK}, 32'd0);
    checkOutput({tag, " nextValid"}, {31'd0, oNEXT_VALID}, 32'd0);
    checkOutput({tag, " nextData"}, oNEXT_DATA, 32'd0);
    checkOutput({tag, " nextFault"}, {31'd0, oNEXT_FAULT}, 32'd0);
  endtask

  // Runs one request from an idle negedge and plays bus and downstream, optionally stalling both.
  task automatic applyStimulus(input vec_t v, input int busStall, input int nextStall, input string tag);
    logic [31:0] gotAddr[2];
    logic [3:0]  gotMask[2];
    logic [31:0] gotData[2];
    logic        gotRw[2];
    logic [31:0] snapAddr, snapData, gotResult;
    logic [3:0]  snapMask;
    logic        gotFault, snapped, respond, done;
    logic [31:0] respAddr;
    int txn, lat, busLeft, nextLeft, expLat;
    txn = 0; lat = -1; busLeft = busStall; nextLeft = nextStall;
    snapped = 1'b0; respond = 1'b0; done = 1'b0;
    respAddr = 32'h0; gotResult = 32'h0; gotFault = 1'b0;
    snapAddr = 32'h0; snapData = 32'h0; snapMask = 4'h0;
    iPREV_VALID = 1'b1; iPREV_RW = v.rw; iPREV_ORDER = v.order;
    iPREV_ADDR = v.addr; iPREV_DATA = v.data;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iPREV_VALID = 1'b0; iPREV_ADDR = 32'hFFFF_FFFF; iPREV_DATA = 32'hFFFF_FFFF; iPREV_RW = ~v.rw;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      iLDST_VALID = 1'b0;
      if (respond) begin
        iLDST_VALID = 1'b1;
        iLDST_DATA = memRead(respAddr);
        respond = 1'b0;
      end
      checkOutput({tag, " prevBusy"}, {31'd0, oPREV_BUSY}, 32'd1);
      if (oLDST_REQ && oNEXT_VALID) checkOutput({tag, " reqInDone"}, 32'd1, 32'd0);
      if (oLDST_REQ) begin
        if (txn == 0 && busStall > 0) begin
          if (!snapped) begin
            snapped = 1'b1; snapAddr = oLDST_ADDR; snapMask = oLDST_MASK; snapData = oLDST_DATA;
          end else begin
            checkOutput({tag, " stallAddr"}, oLDST_ADDR, snapAddr);
            checkOutput({tag, " stallMask"}, {28'd0, oLDST_MASK}, {28'd0, snapMask});
            checkOutput({tag, " stallData"}, oLDST_DATA, snapData);
          end
        end
        if (busLeft > 0) begin
          iLDST_BUSY = 1'b1;
          busLeft--;
        end else begin
          iLDST_BUSY = 1'b0;
          if (txn < 2) begin
            gotAddr[txn] = oLDST_ADDR; gotMask[txn] = oLDST_MASK;
            gotData[txn] = oLDST_DATA; gotRw[txn] = oLDST_RW;
          end
          respAddr = oLDST_ADDR;
          txn++;
          respond = 1'b1;
        end
      end else begin
        iLDST_BUSY = 1'b0;
      end
      if (oNEXT_VALID) begin
        if (lat < 0) begin
          lat = cyc; gotResult = oNEXT_DATA; gotFault = oNEXT_FAULT;
        end else begin
          checkOutput({tag, " holdData"}, oNEXT_DATA, gotResult);
          checkOutput({tag, " holdFault"}, {31'd0, oNEXT_FAULT}, {31'd0, gotFault});
        end
        if (nextLeft > 0) begin
          iNEXT_BUSY = 1'b1;
          nextLeft--;
        end else begin
          iNEXT_BUSY = 1'b0;
          done = 1'b1;
        end
      end
      @(negedge iCLOCK);
    end
    iNEXT_BUSY = 1'b0; iLDST_VALID = 1'b0; iLDST_BUSY = 1'b0;
    if (!done) begin
      checkOutput({tag, " timeout"}, 32'd1, 32'd0);
    end else begin
      expLat = ((v.nTxn == 0) ? 1 : 2 * v.nTxn + 1) + busStall;
      checkOutput({tag, " txnCount"}, txn, v.nTxn);
      if (v.nTxn >= 1 && txn >= 1) begin
        checkOutput({tag, " addr0"}, gotAddr[0], v.addr0);
        checkOutput({tag, " mask0"}, {28'd0, gotMask[0]}, {28'd0, v.mask0});
        checkOutput({tag, " rw0"}, {31'd0, gotRw[0]}, {31'd0, v.rw});
        if (v.rw) checkOutput({tag, " data0"}, gotData[0], v.data0);
      end
      if (v.nTxn >= 2 && txn >= 2) begin
        checkOutput({tag, " addr1"}, gotAddr[1], v.addr1);
        checkOutput({tag, " mask1"}, {28'd0, gotMask[1]}, {28'd0, v.mask1});
        checkOutput({tag, " rw1"}, {31'd0, gotRw[1]}, {31'd0, v.rw});
        if (v.rw) checkOutput({tag, " data1"}, gotData[1], v.data1);
      end
      checkOutput({tag, " result"}, gotResult, v.result);
      checkOutput({tag, " fault"}, {31'd0, gotFault}, {31'd0, v.fault});
      checkOutput({tag, " latency"}, lat, expLat);
      checkOutput({tag, " busyAfter"}, {31'd0, oPREV_BUSY}, 32'd0);
      checkOutput({tag, " validAfter"}, {31'd0, oNEXT_VALID}, 32'd0);
    end
  endtask

  initial begin
    // rw, order, addr, data, nTxn, addr0, mask0, data0, addr1, mask1, data1, result, fault
    vecs.push_back('{1'b0, 2'd2, 32'h1000, 32'h0, 1, 32'h1000, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hAABBCCDD, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 32'h1003, 32'h0, 1, 32'h1000, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h000000AA, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 32'h1002, 32'h0, 1, 32'h1000, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000AABB, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 32'h1005, 32'h0, 1, 32'h1004, 4'h2, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000033, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 32'h1001, 32'h0, 1, 32'h1000, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000BBCC, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 32'h1003, 32'hA5, 1, 32'h1000, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 32'h1002, 32'hBEEF, 1, 32'h1000, 4'hC, 32'hBEEF0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 32'h2000, 32'h12345678, 1, 32'h2000, 4'hF, 32'h12345678, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 2'd3, 32'h1000, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1});
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
    vecs.push_back('{1'b0, 2'd2, 32'h1002, 32'h0, 2, 32'h1000, 4'hC, 32'h0, 32'h1004, 4'h3, 32'h0, 32'h3344AABB, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 32'h1003, 32'h12345678, 2, 32'h1000, 4'h8, 32'h78000000, 32'h1004, 4'h7, 32'h00123456, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 32'h1003, 32'h0, 2, 32'h1000, 4'h8, 32'h0, 32'h1004, 4'h1, 32'h0, 32'h000044AA, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 2, 32'hFFFFFFFC, 4'hC, 32'h0, 32'h0, 4'h3, 32'h0, 32'h03040102, 1'b0});
`else
    vecs.push_back('{1'b0, 2'd2, 32'h1002, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 32'h1003, 32'h12345678, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'd1, 32'h1003, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1});
`endif

    repeat (3) @(posedge iCLOCK);
    @(negedge iCLOCK);
    checkResetState("reset");
    iRESET_SYNC = 1'b0;
    @(negedge iCLOCK);
    checkResetState("idle");

    foreach (vecs[i]) applyStimulus(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Bus and downstream stalls on a plain word load.
    applyStimulus(vecs[0], 5, 3, "stall");

    // Reset while a bus completion is still owed, followed by a stale completion.
    iPREV_VALID = 1'b1; iPREV_RW = 1'b0; iPREV_ORDER = 2'd2;
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
    iPREV_ADDR = 32'h1002;
`else
    iPREV_ADDR = 32'h1000;
`endif
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iPREV_VALID = 1'b0;
    checkOutput("midReset req0", {31'd0, oLDST_REQ}, 32'd1);
    @(posedge iCLOCK);
    @(negedge iCLOCK);
`ifdef EXE_LDST_MISALIGN_SPLIT_EN
    iLDST_VALID = 1'b1; iLDST_DATA = 32'hAABBCCDD;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iLDST_VALID = 1'b0;
    checkOutput("midReset req1", {31'd0, oLDST_REQ}, 32'd1);
    checkOutput("midReset addr1", oLDST_ADDR, 32'h1004);
    @(posedge iCLOCK);
    @(negedge iCLOCK);
`endif
    checkOutput("midReset waitReq", {31'd0, oLDST_REQ}, 32'd0);
    checkOutput("midReset waitBusy", {31'd0, oPREV_BUSY}, 32'd1);
    iRESET_SYNC = 1'b1;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    checkResetState("midReset");
    iLDST_VALID = 1'b1; iLDST_DATA = 32'hDEADBEEF;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iLDST_VALID = 1'b0;
    checkResetState("stale");
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    checkOutput("stale nextValid", {31'd0, oNEXT_VALID}, 32'd0);
    applyStimulus(vecs[0], 0, 0, "afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_ldst_align_unit.md
Name: execute_ldst_align_unit

Overview:
Sequential successor to the combinational load/store address/mask calculator in the execute stage. Accepts one load/store request at a time and drives bus-aligned transactions to the LDST pipe with byte masks and lane-shifted store data. A misaligned access that crosses a bus word is split into two transactions. Returned load data is merged and right-justified before being handed to writeback.

Parameters:
P_DATA_W, 32, bus data width in bits; legal values 32 or 64.
P_ADDR_W, 32, address width in bits.
P_LANE_W, P_DATA_W/8, number of byte lanes; derived, not overridable.

Ports:
iCLOCK  in  1  clock; all logic on rising edge.
iRESET_SYNC  in  1  synchronous reset, active-high.
iPREV_VALID  in  1  request valid.
oPREV_BUSY  out  1  unit cannot accept a request.
iPREV_RW  in  1  0 = load, 1 = store.
iPREV_ORDER  in  2  access size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit (legal only when P_DATA_W = 64).
iPREV_ADDR  in  P_ADDR_W  byte address.
iPREV_DATA  in  P_DATA_W  store data, right-justified.
oLDST_REQ  out  1  bus request.
iLDST_BUSY  in  1  bus stall.
oLDST_RW  out  1  bus direction.
oLDST_ADDR  out  P_ADDR_W  bus-word-aligned address; low log2(P_LANE_W) bits are 0.
oLDST_DATA  out  P_DATA_W  lane-shifted store data.
oLDST_MASK  out  P_LANE_W  byte enables; bit n = lane n, little-endian.
iLDST_VALID  in  1  load or store completion, returned in order.
iLDST_DATA  in  P_DATA_W  load data.
oNEXT_VALID  out  1  result valid.
iNEXT_BUSY  in  1  downstream stall.
oNEXT_DATA  out  P_DATA_W  load result, right-justified and zero-extended; 0 for stores.
oNEXT_FAULT  out  1  illegal order, or misaligned access when splitting is compiled out.

Behaviour:
- Reset: state goes to IDLE. oPREV_BUSY=0, oLDST_REQ=0, oLDST_RW=0, oLDST_ADDR=0, oLDST_DATA=0, oLDST_MASK=0, oNEXT_VALID=0, oNEXT_DATA=0, oNEXT_FAULT=0.
- Reset mid-operation: any in-flight bus completion is discarded. A completion arriving after reset is ignored.
- Registers: request fields are captured when iPREV_VALID && !oPREV_BUSY. oPREV_BUSY=1 in every state except IDLE.
- Offset: off = addr mod P_LANE_W; size = 1 << order.
- Mask: first mask = ((1<<size)-1) << off, truncated to P_LANE_W. Split when off + size > P_LANE_W. Second mask = ((1<<size)-1) >> (P_LANE_W-off).
- Store data: first beat = data << (8*off). Second beat = data >> (8*(P_LANE_W-off)).
- Addresses: second transaction address = first aligned address + P_LANE_W. Wrap-around at the top of address space is modulo 2^P_ADDR_W.
- States:
  - IDLE: on accept, go to REQ0. If the order is illegal, skip the bus and go to DONE with fault.
  - REQ0: oLDST_REQ=1. Outputs hold while iLDST_BUSY=1. When !iLDST_BUSY, go to WAIT0.
  - WAIT0: on iLDST_VALID, capture data. Go to REQ1 if split, else DONE.
  - REQ1: same handshake as REQ0. When !iLDST_BUSY, go to WAIT1.
  - WAIT1: on iLDST_VALID, merge and go to DONE.
  - DONE: oNEXT_VALID=1; outputs hold while iNEXT_BUSY. Return to IDLE on the first cycle with !iNEXT_BUSY. No new request is accepted in that same cycle; oPREV_BUSY falls the next cycle.
- Load merge: result = ({beat1,beat0} >> 8*off) & size-mask, zero-extended.
- Latency: unsplit access = 3 cycles plus bus wait (accept, REQ0, WAIT0, DONE). A split access adds 2 cycles.
- Other rules:
  - oLDST_REQ is never asserted in WAIT or DONE states.
  - At most one outstanding bus transaction.
  - An iLDST_VALID outside a WAIT state is ignored.

Optional Feature:
EXE_LDST_MISALIGN_SPLIT_EN.
- Defined: misaligned crossing accesses are split as above.
- Undefined: REQ1/WAIT1 are not built. A crossing access issues no bus request and goes IDLE→DONE with oNEXT_FAULT=1 and oNEXT_DATA=0. Non-crossing misaligned accesses (e.g. 8-bit at off 3) are still legal.

Test Plan:
1. P_DATA_W=32; load order=2 at 0x1000, bus returns 0xAABBCCDD → one transaction, mask 1111, addr 0x1000; oNEXT_DATA=0xAABBCCDD, fault=0.
2. Memory 0x1000=0xAABBCCDD, 0x1004=0x11223344; load order=2 at 0x1002 with split enabled → transactions 0x1000 mask 1100, then 0x1004 mask 0011; oNEXT_DATA=0x3344AABB.
3. Store order=2 at 0x1003, data 0x12345678 → beat0 addr 0x1000, mask 1000, data 0x78000000; beat1 addr 0x1004, mask 0111, data 0x00123456; oNEXT_DATA=0.
4. Hold iLDST_BUSY=1 for 5 cycles in REQ0, then iNEXT_BUSY=1 for 3 cycles in DONE → bus outputs stable while stalled, oNEXT_VALID held, oPREV_BUSY=1 throughout.
5. Split disabled, load order=1 at 0x1003 → no oLDST_REQ; oNEXT_FAULT=1, oNEXT_DATA=0. Then P_DATA_W=32 with order=3 → fault=1 in both builds.
6. Assert iRESET_SYNC during WAIT1, then a stale iLDST_VALID arrives → all outputs at reset values, no oNEXT_VALID, next request completes normally.
